// File: rtl/uart_tx_drain_pkg.sv
// uart_tx_drain_pkg: shared UART constants, FSM state encodings and divider helpers
// Contents: OVERSAMPLE (ticks per bit), S_* state codes, clogb2(), ovs_div()
package uart_tx_drain_pkg;
  localparam int OVERSAMPLE = 16;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  function automatic int clogb2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // Rounded clock/(baud*16), never below 1 so the tick generator always runs.
  function automatic int ovs_div(input int clock_rate, input int baud_rate);
    int d;
    d = (clock_rate + baud_rate * OVERSAMPLE / 2) / (baud_rate * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_tx_drain_baud_gen.sv
// uart_tx_drain_baud_gen: free-running 16x oversample tick generator
// Ports: clk, rst (async, active-high) in; baud_x16_en out (1-cycle pulse every OVS_DIV clocks)
module uart_tx_drain_baud_gen
  import uart_tx_drain_pkg::*;
#(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic clk,
  input  logic rst,
  output logic baud_x16_en
);
  localparam int OVS_DIV = ovs_div(CLOCK_RATE, BAUD_RATE);
  localparam int CW = clogb2(OVS_DIV);
  localparam logic [CW-1:0] LAST = CW'(OVS_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    baud_x16_en = cnt_q == LAST;
    cnt_d = baud_x16_en ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops a FWFT char FIFO and serialises each character 8N1 onto txd_tx
// Ports: clk_tx, rst_clk_tx (async, active-high), char_fifo_empty, char_fifo_dout[7:0] in;
//        char_fifo_rd_en (pop strobe), txd_tx (idle high), tx_busy out
// Build option: define UART_TX_PARITY_EN to add an even parity bit after the data bits.
module uart_tx_drain
  import uart_tx_drain_pkg::*;
#(
  parameter int CLOCK_RATE = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk_tx,
  input  logic       rst_clk_tx,
  input  logic       char_fifo_empty,
  input  logic [7:0] char_fifo_dout,
  output logic       char_fifo_rd_en,
  output logic       txd_tx,
  output logic       tx_busy
);
  logic       baud_x16_en, last;
  logic [2:0] state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif
  uart_tx_drain_baud_gen #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_gen (
    .clk        (clk_tx),
    .rst        (rst_clk_tx),
    .baud_x16_en(baud_x16_en)
  );
  always_comb begin
    // last: the 16th tick of the current bit period
    last = baud_x16_en && tick_cnt_q == 4'hF;
    // Pop from IDLE on any tick, or on the final stop tick for back-to-back frames.
    char_fifo_rd_en = baud_x16_en && !char_fifo_empty &&
                      (state_q == S_IDLE || (state_q == S_STOP && last));
    state_d    = state_q;
    tick_cnt_d = state_q == S_IDLE ? 4'd0 : tick_cnt_q + {3'd0, baud_x16_en};
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    txd_d      = txd_q;
`ifdef UART_TX_PARITY_EN
    par_d = char_fifo_rd_en ? ^char_fifo_dout : par_q;
`endif
    if (char_fifo_rd_en) begin
      state_d    = S_START;
      tick_cnt_d = 4'd0;
      shift_d    = char_fifo_dout;
      txd_d      = 1'b0;
    end else if (last) begin
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
        S_DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            txd_d = shift_q[0];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
`endif
        default: begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk_tx or posedge rst_clk_tx) begin
    if (rst_clk_tx) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      txd_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end
  assign txd_tx  = txd_q;
  assign tx_busy = state_q != S_IDLE;
endmodule
